retro_cache_line_filler: RTL

RETRO_CACHE_LINE_FILLER -- requirements
Module: retro_cache_line_filler

---
 rtl/retro_cache_line_filler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/retro_cache_line_filler.sv
// Cache line filler: on a read miss, fetches the whole aligned line word by word from
// backing storage and writes it into the cache, stalling the core until the line is complete.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | watching the core for a read miss
//   REQ   | read request to backing storage, held until accepted
//   WAIT  | request accepted, waiting for the read data
//   WRITE | one-cycle write of the captured word into the cache
//   DONE  | one-cycle completion pulse, then back to IDLE
module retro_cache_line_filler #(
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 8,
    parameter int CacheLineBits   = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       core_access_i,
    input  logic                       core_write_i,
    input  logic [AddressBusWidth-1:0] core_address_i,
    input  logic                       cache_data_ready_i,
    output logic                       delay_o,
    output logic                       fill_access_o,
    output logic [AddressBusWidth-1:0] fill_address_o,
    output logic [DataBusWidth-1:0]    fill_data_o,
    output logic                       back_access_o,
    output logic [AddressBusWidth-1:0] back_address_o,
    input  logic                       back_ready_i,
    input  logic                       back_data_ready_i,
    input  logic [DataBusWidth-1:0]    back_data_i,
    output logic                       busy_o,
    output logic                       fill_done_o
);

    localparam logic [AddressBusWidth-1:0] OffsetMask =
        AddressBusWidth'((1 << CacheLineBits) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [CacheLineBits-1:0]   offset_q, offset_d;
    logic [AddressBusWidth-1:0] line_base_q, line_base_d;
    logic [DataBusWidth-1:0]    data_q, data_d;
    logic                       miss;
    logic [AddressBusWidth-1:0] word_addr;

    assign miss      = (state_q == S_IDLE) && core_access_i && !core_write_i
                       && !cache_data_ready_i;
    assign word_addr = line_base_q | AddressBusWidth'(offset_q);

    // The miss term is combinational from the core inputs, so reset must mask it too.
    assign delay_o = rst_n_i && (miss || (state_q != S_IDLE));
    assign busy_o  = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            offset_q    <= '0;
            line_base_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            line_base_q <= line_base_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        offset_d       = offset_q;
        line_base_d    = line_base_q;
        data_d         = data_q;
        fill_access_o  = 1'b0;
        fill_address_o = '0;
        fill_data_o    = '0;
        back_access_o  = 1'b0;
        back_address_o = '0;
        fill_done_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    line_base_d = core_address_i & ~OffsetMask;
                    offset_d    = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                back_access_o  = 1'b1;
                back_address_o = word_addr;
                if (back_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (back_data_ready_i) begin
                    data_d  = back_data_i;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                fill_access_o  = 1'b1;
                fill_address_o = word_addr;
                fill_data_o    = data_q;
                if (offset_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    offset_d = offset_q + 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_DONE: begin
                fill_done_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
